// File: rtl/pwr_seq_pkg.sv
// Shared definitions for the power/reset sequencer.
// Contents: 3-bit state encoding and a helper that sizes a counter so it
// can hold the largest of up to three cycle counts.
package pwr_seq_pkg;

  localparam int unsigned PWR_STATE_W = 3;

  typedef logic [PWR_STATE_W-1:0] pwr_state_t;

  localparam pwr_state_t PWR_OFF   = 3'd0;
  localparam pwr_state_t PWR_WAKE  = 3'd1;
  localparam pwr_state_t PWR_HOLD  = 3'd2;
  localparam pwr_state_t PWR_RUN   = 3'd3;
  localparam pwr_state_t PWR_DRAIN = 3'd4;
  localparam pwr_state_t PWR_REARM = 3'd5;

  // Width needed to count up to the largest argument without wrapping.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pwr_seq_ctrl_if.sv
// Signal bundle between the sequencer, the UART pins and the SoC core.
// master: the sequencer (drives pin-side UART, soc_resetn, debug/status).
// slave : the surroundings (host CTS, SoC UART, firmware requests).
interface pwr_seq_ctrl_if;
  import pwr_seq_pkg::*;

  logic       uart_cts;
  logic       poweroff_rq;
  logic       soc_tx;
  logic       soc_rts;
  logic       wdt_kick;
  logic       uart_tx;
  logic       uart_rts;
  logic       soc_resetn;
  pwr_state_t pwr_state;
  logic       wdt_fired;

  modport master (
    input  uart_cts, poweroff_rq, soc_tx, soc_rts, wdt_kick,
    output uart_tx, uart_rts, soc_resetn, pwr_state, wdt_fired
  );

  modport slave (
    output uart_cts, poweroff_rq, soc_tx, soc_rts, wdt_kick,
    input  uart_tx, uart_rts, soc_resetn, pwr_state, wdt_fired
  );
endinterface

// File: rtl/pwr_seq_wdt.sv
// Firmware watchdog for the RUN state.
// Ports: clk, resetn (sync, active low), i_en (high while in RUN),
//        i_kick (firmware kick), o_expire_c (combinational expiry strobe).
// Counter is held at zero outside RUN so every RUN entry starts fresh; a kick
// on the expiry cycle suppresses expiry.
module pwr_seq_wdt
  import pwr_seq_pkg::*;
#(
  parameter int unsigned WDT_CYCLES = 16777216
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_en,
  input  logic i_kick,
  output logic o_expire_c
);

  localparam int unsigned         WDT_W    = cnt_width(WDT_CYCLES, 1, 1);
  localparam logic [WDT_W-1:0]    WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] r_cnt;

  // Age since RUN entry or last kick; holds at terminal so it never wraps.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (!i_en || i_kick) begin
      r_cnt <= '0;
    end else if (r_cnt != WDT_LAST) begin
      r_cnt <= r_cnt + WDT_W'(1);
    end
  end

  assign o_expire_c = i_en && !i_kick && (r_cnt == WDT_LAST);

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Power/reset sequencer between the board UART pins and the SoC core.
// Ports: clk, resetn (sync, active low), bus (pwr_seq_ctrl_if.master):
//   in : uart_cts (low = wake), poweroff_rq, soc_tx, soc_rts, wdt_kick
//   out: uart_tx, uart_rts (SoC lines passed through only in RUN),
//        soc_resetn (registered), pwr_state (debug), wdt_fired (sticky).
// Optional build macro PWRSEQ_WDT_EN adds a RUN-state watchdog that forces
// poweroff; without it wdt_kick is unused and wdt_fired is tied 0.
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int unsigned WAKE_FILTER_CYCLES = 4,
  parameter int unsigned RESET_HOLD_CYCLES  = 16,
  parameter int unsigned QUIESCE_CYCLES     = 32,
  parameter int unsigned WDT_CYCLES         = 16777216
) (
  input  logic          clk,
  input  logic          resetn,
  pwr_seq_ctrl_if.master bus
);

  localparam int unsigned      CNT_W = cnt_width(WAKE_FILTER_CYCLES, RESET_HOLD_CYCLES,
                                                 QUIESCE_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(QUIESCE_CYCLES - 1);

  pwr_state_t       r_state;
  pwr_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_soc_resetn;
  logic             w_wdt_expire;
  logic             w_wdt_fired;
  logic             w_uart_tx;
  logic             w_uart_rts;

  // State register and shared phase counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= PWR_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter logic; counter is zero on every phase entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      PWR_OFF: begin
        if (!bus.uart_cts) w_state_nxt = PWR_WAKE;
      end
      PWR_WAKE: begin
        // Any high cycle is a bounce and restarts the filter from OFF.
        if (bus.uart_cts)            w_state_nxt = PWR_OFF;
        else if (r_cnt == WAKE_LAST) w_state_nxt = PWR_HOLD;
        else                         w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      PWR_HOLD: begin
        if (r_cnt == HOLD_LAST) w_state_nxt = PWR_RUN;
        else                    w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      PWR_RUN: begin
        if (bus.poweroff_rq || w_wdt_expire) w_state_nxt = PWR_DRAIN;
      end
      PWR_DRAIN: begin
        if (r_cnt == DRAIN_LAST) w_state_nxt = PWR_REARM;
        else                     w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      PWR_REARM: begin
        // Wait for host to release CTS so a held-low CTS cannot re-wake.
        if (bus.uart_cts) w_state_nxt = PWR_OFF;
      end
      default: w_state_nxt = PWR_OFF;
    endcase
  end

  // UART pin mux, selected by the state register only.
  always_comb begin
    w_uart_tx  = 1'b1;
    w_uart_rts = 1'b1;
    if (r_state == PWR_RUN) begin
      w_uart_tx  = bus.soc_tx;
      w_uart_rts = bus.soc_rts;
    end
  end

  // SoC reset released one cycle into RUN and asserted with the RUN exit edge.
  always_ff @(posedge clk) begin
    if (!resetn) r_soc_resetn <= 1'b0;
    else         r_soc_resetn <= (r_state == PWR_RUN) && (w_state_nxt == PWR_RUN);
  end

`ifdef PWRSEQ_WDT_EN
  logic r_wdt_fired;

  pwr_seq_wdt #(
    .WDT_CYCLES (WDT_CYCLES)
  ) u_wdt (
    .clk        (clk),
    .resetn     (resetn),
    .i_en       (r_state == PWR_RUN),
    .i_kick     (bus.wdt_kick),
    .o_expire_c (w_wdt_expire)
  );

  // Cause of the most recent RUN exit; poweroff_rq wins a tie with expiry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wdt_fired <= 1'b0;
    end else if (r_state == PWR_RUN) begin
      if (bus.poweroff_rq)   r_wdt_fired <= 1'b0;
      else if (w_wdt_expire) r_wdt_fired <= 1'b1;
    end
  end

  assign w_wdt_fired = r_wdt_fired;
`else
  localparam int unsigned unused_wdt_cycles = WDT_CYCLES;
  logic w_unused_kick;

  assign w_unused_kick = bus.wdt_kick;
  assign w_wdt_expire  = 1'b0;
  assign w_wdt_fired   = 1'b0;
`endif

  assign bus.uart_tx    = w_uart_tx;
  assign bus.uart_rts   = w_uart_rts;
  assign bus.soc_resetn = r_soc_resetn;
  assign bus.pwr_state  = r_state;
  assign bus.wdt_fired  = w_wdt_fired;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Self-checking bench for pwr_seq_ctrl: directed scenarios plus randomized
// traffic, all compared every cycle against a timestamp-based reference model.
module tb_pwr_seq_ctrl;

  localparam int unsigned WF  = 4;
  localparam int unsigned RH  = 16;
  localparam int unsigned QC  = 32;
  localparam int unsigned WDT = 100;
`ifdef PWRSEQ_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  localparam int S_OFF = 0, S_WAKE = 1, S_HOLD = 2, S_RUN = 3, S_DRAIN = 4, S_REARM = 5;

  logic clk;
  logic resetn;

  pwr_seq_ctrl_if u_if ();

  pwr_seq_ctrl #(
    .WAKE_FILTER_CYCLES (WF),
    .RESET_HOLD_CYCLES  (RH),
    .QUIESCE_CYCLES     (QC),
    .WDT_CYCLES         (WDT)
  ) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cyc      = 0;

  // Reference model: phase plus elapsed-cycle bookkeeping.
  int          m_ph    = S_OFF;
  int          m_t     = 0;
  int          m_low   = 0;
  int unsigned m_ref   = 0;
  bit          m_rstn  = 1'b0;
  bit          m_fired = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, obs, exp);
  endtask

  task automatic model_update();
    int prev;
    prev = m_ph;
    cyc++;
    if (!resetn) begin
      m_ph = S_OFF; m_t = 0; m_low = 0; m_rstn = 1'b0; m_fired = 1'b0;
      return;
    end
    case (prev)
      S_OFF:   if (!u_if.uart_cts) begin m_ph = S_WAKE; m_low = 0; end
      S_WAKE: begin
        if (u_if.uart_cts) m_ph = S_OFF;
        else begin
          m_low++;
          if (m_low == int'(WF)) begin m_ph = S_HOLD; m_t = 0; end
        end
      end
      S_HOLD: begin
        m_t++;
        if (m_t == int'(RH)) begin m_ph = S_RUN; m_ref = cyc; end
      end
      S_RUN: begin
        // cycle being evaluated is cyc-1; m_ref is the first cycle of the watchdog window
        if (u_if.poweroff_rq) begin
          m_ph = S_DRAIN; m_t = 0; m_fired = 1'b0;
        end else if (WDT_ON && !u_if.wdt_kick && (cyc - 1 - m_ref) == WDT - 1) begin
          m_ph = S_DRAIN; m_t = 0; m_fired = 1'b1;
        end else if (WDT_ON && u_if.wdt_kick) begin
          m_ref = cyc;
        end
      end
      S_DRAIN: begin
        m_t++;
        if (m_t == int'(QC)) m_ph = S_REARM;
      end
      S_REARM: if (u_if.uart_cts) m_ph = S_OFF;
      default: m_ph = S_OFF;
    endcase
    m_rstn = (prev == S_RUN) && (m_ph == S_RUN);
  endtask

  task automatic check_lines();
    chk("uart_tx",  32'(u_if.uart_tx),  32'((m_ph == S_RUN) ? u_if.soc_tx  : 1'b1));
    chk("uart_rts", 32'(u_if.uart_rts), 32'((m_ph == S_RUN) ? u_if.soc_rts : 1'b1));
  endtask

  task automatic check_outputs();
    chk("pwr_state",  32'(u_if.pwr_state),  32'(m_ph));
    chk("soc_resetn", 32'(u_if.soc_resetn), 32'(m_rstn));
    chk("wdt_fired",  32'(u_if.wdt_fired),  32'(m_fired));
    check_lines();
  endtask

  // Drive inputs mid-cycle, check the pass-through, then clock and check all.
  task automatic tick(bit cts, bit prq, bit tx, bit rts, bit kick);
    u_if.uart_cts    = cts;
    u_if.poweroff_rq = prq;
    u_if.soc_tx      = tx;
    u_if.soc_rts     = rts;
    u_if.wdt_kick    = kick;
    #1;
    check_lines();
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic go_run();
    int n;
    n = 0;
    while (u_if.pwr_state != 3'd0 && n < 200) begin tick(1, 0, 1, 1, 0); n++; end
    n = 0;
    while (u_if.pwr_state != 3'd3 && n < 200) begin tick(0, 0, 1, 1, 0); n++; end
    chk("reach_run", 32'(u_if.pwr_state), 32'd3);
  endtask

  task automatic wdt_starve(bit prq_on_expiry);
    go_run();
    for (int i = 0; i < int'(WDT) - 1; i++) tick(0, 0, 1'(i), 1, 0);
    chk("wdt_pre", 32'(u_if.pwr_state), 32'd3);
    tick(0, prq_on_expiry, 1, 1, 0);
    chk("wdt_drain", 32'(u_if.pwr_state), 32'd4);
    chk("wdt_flag",  32'(u_if.wdt_fired), 32'(!prq_on_expiry));
  endtask

  initial begin
    int lat;
    int seg;
    bit lvl;

    resetn = 1'b0;
    u_if.uart_cts = 1'b1; u_if.poweroff_rq = 1'b0; u_if.soc_tx = 1'b1;
    u_if.soc_rts = 1'b1;  u_if.wdt_kick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); model_update(); #1; check_outputs();
    end
    chk("rst_state", 32'(u_if.pwr_state), 32'd0);
    chk("rst_soc_resetn", 32'(u_if.soc_resetn), 32'd0);

    // Basic wake: cts low after 10 idle cycles.
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) tick(1, 0, 1, 1, 0);
    lat = 0;
    do begin tick(0, 0, 1, 1, 0); lat++; end while (u_if.pwr_state != 3'd3 && lat < 100);
    chk("wake_latency", 32'(lat), 32'(1 + WF + RH));
    chk("rstn_low_at_entry", 32'(u_if.soc_resetn), 32'd0);
    tick(0, 0, 1, 1, 0);
    chk("rstn_rise", 32'(u_if.soc_resetn), 32'd1);

    // Pass-through, then poweroff and drain with CTS still low.
    for (int i = 0; i < 8; i++) tick(0, 0, 1'(i), 1'(i >> 1), 0);
    tick(0, 1, 0, 0, 0);
    chk("rstn_fall", 32'(u_if.soc_resetn), 32'd0);
    for (int i = 0; i < int'(QC) + 10; i++) tick(0, 0, 0, 0, 0);
    chk("rearm_hold", 32'(u_if.pwr_state), 32'd5);
    tick(1, 0, 0, 0, 0);
    chk("rearm_exit", 32'(u_if.pwr_state), 32'd0);

    // Bounce rejection.
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 1, 0);
    tick(1, 0, 1, 1, 0);
    chk("bounce_off", 32'(u_if.pwr_state), 32'd0);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 1, 0);
    chk("bounce_still_wake", 32'(u_if.pwr_state), 32'd1);
    tick(0, 0, 1, 1, 0);
    chk("bounce_hold", 32'(u_if.pwr_state), 32'd2);

    // Reset mid-HOLD at counter 7.
    for (int i = 0; i < 7; i++) tick(1, 0, 1, 1, 0);
    resetn = 1'b0;
    tick(1, 0, 1, 1, 0);
    chk("midhold_rst", 32'(u_if.pwr_state), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 30; i++) tick(1, 0, 1, 1, 0);
    chk("midhold_no_run", 32'(u_if.pwr_state), 32'd0);

`ifdef PWRSEQ_WDT_EN
    wdt_starve(1'b0);
    wdt_starve(1'b1);
    wdt_starve(1'b0);
    go_run();
    for (int i = 0; i < 300; i++) tick(0, 0, 1'(i), 1, 1'(i % 50 == 49));
    chk("kick_stay_run", 32'(u_if.pwr_state), 32'd3);
    chk("kick_flag_held", 32'(u_if.wdt_fired), 32'd1);
    tick(0, 1, 1, 1, 0);
    chk("prq_clears_flag", 32'(u_if.wdt_fired), 32'd0);
`endif

    // Randomized traffic against the model.
    seg = 0;
    lvl = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        seg = int'($urandom_range(1, 25));
        lvl = ($urandom_range(0, 9) < 3);
      end
      seg--;
      resetn = ($urandom_range(0, 399) != 0);
      tick(lvl, ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
